exc_seq_ctrl: RTL and testbench

- Exception/interrupt entry-and-return sequencer for the CP0 coprocessor in the pipelined MIPS CPU.
- Watches the CP0 interrupt request and ERET in the MEM stage, then drains any busy multiply/divide.
- Drives CP0's EPCWr/EXLSet/EXLClr/PC inputs and issues pipeline flush and PC redirect to the handler or to EPC.
- Sits between the CP0, the hazard/stall unit and the PC-select mux.

---
 rtl/exc_pkg.sv | 24 ++
 rtl/exc_drain_timer.sv | 56 +++++
 rtl/exc_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_exc_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the CP0 exception/interrupt entry-and-return sequencer.
//
// Contents:
//   exc_state_e         - sequencer state encoding
//   HandlerAddrDefault  - default exception handler byte address
//   Cp0Reg*             - CP0 register select numbers (SR, Cause, EPC, PRId)
package exc_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDrain  = 3'd1,
    StSave   = 3'd2,
    StVector = 3'd3,
    StEret   = 3'd4
  } exc_state_e;

  localparam logic [31:0] HandlerAddrDefault = 32'h0000_4180;

  localparam logic [4:0] Cp0RegSr    = 5'd12;
  localparam logic [4:0] Cp0RegCause = 5'd13;
  localparam logic [4:0] Cp0RegEpc   = 5'd14;
  localparam logic [4:0] Cp0RegPrid  = 5'd15;

endpackage

// File: rtl/exc_drain_timer.sv
// Bounded wait counter for draining a busy multiply/divide unit before
// exception entry.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-low reset
//   en      in   count this cycle (sequencer is waiting)
//   clr     in   return the count to zero (sequencer leaves the wait)
//   tc      out  count has reached DRAIN_MAX-1 (last permitted wait cycle)
//   timeout out  sticky: the wait hit its terminal count at least once
module exc_drain_timer #(
  parameter int unsigned DRAIN_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc,
  output logic timeout
);

  localparam int unsigned CntW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_MAX - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  // The sequencer always leaves the wait at CntLast, so the count never wraps.
  assign tc = (cnt_q == CntLast);

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (en && tc) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/exc_seq_ctrl.sv
// Exception/interrupt entry-and-return sequencer for CP0.
// Detects a taken interrupt or ERET in the MEM stage, waits for a busy
// multiply/divide to drain (bounded), then pulses CP0 EPC/EXL controls and
// redirects the PC to the handler or back to EPC, flushing the pipeline.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-low reset
//   int_req       in   CP0 IntReq (already masked)
//   eret          in   ERET decoded in MEM
//   mem_valid     in   MEM-stage instruction valid
//   mem_pc        in   PC[31:2] of the MEM-stage instruction
//   md_busy       in   mult/div unit busy
//   epc           in   CP0 EPC[31:2]
//   cp0_pc        out  PC presented to CP0 (the saved interrupted PC)
//   epc_wr        out  CP0 EPCWr
//   exl_set       out  CP0 EXLSet
//   exl_clr       out  CP0 EXLClr
//   flush         out  squash IF/ID/EX/MEM
//   pc_redirect   out  PC mux selects redirect_pc
//   redirect_pc   out  redirect target PC[31:2]
//   stall         out  freeze PC and pipeline registers
//   drain_timeout out  sticky: drain wait expired at least once
module exc_seq_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HandlerAddrDefault,
  parameter int unsigned DRAIN_MAX    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        eret,
  input  logic        mem_valid,
  input  logic [29:0] mem_pc,
  input  logic        md_busy,
  input  logic [29:0] epc,
  output logic [29:0] cp0_pc,
  output logic        epc_wr,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        flush,
  output logic        pc_redirect,
  output logic [29:0] redirect_pc,
  output logic        stall,
  output logic        drain_timeout
);

  localparam logic [29:0] HandlerPc = HANDLER_ADDR[31:2];

  exc_state_e  state_q, state_d;
  logic [29:0] saved_pc_q, saved_pc_d;

  logic take_int;
  logic take_eret;
  logic drain_en;
  logic drain_clr;
  logic drain_tc;

  // Gated by rst so nothing is requested while reset is held.
  assign take_int  = rst & int_req & mem_valid;
  // Interrupt wins; the squashed ERET re-executes after return.
  assign take_eret = rst & eret & mem_valid & ~int_req;

  assign drain_en  = (state_q == StDrain);
  assign drain_clr = drain_en & (state_d != StDrain);

  exc_drain_timer #(
    .DRAIN_MAX (DRAIN_MAX)
  ) u_drain_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (drain_en),
    .clr     (drain_clr),
    .tc      (drain_tc),
    .timeout (drain_timeout)
  );

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    saved_pc_d = saved_pc_q;
    unique case (state_q)
      StIdle: begin
        if (take_int) begin
          saved_pc_d = mem_pc;
          state_d    = md_busy ? StDrain : StSave;
        end else if (take_eret) begin
          state_d = StEret;
        end
      end
      StDrain: begin
        // Interrupt is already committed; int_req is no longer consulted.
        if (!md_busy || drain_tc) begin
          state_d = StSave;
        end
      end
      StSave:   state_d = StVector;
      StVector: state_d = StIdle;
      StEret:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      saved_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      saved_pc_q <= saved_pc_d;
    end
  end

  // Moore output decode; redirect_pc in ERET passes epc straight through.
  always_comb begin
    epc_wr      = 1'b0;
    exl_set     = 1'b0;
    exl_clr     = 1'b0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    unique case (state_q)
      StIdle, StDrain: ;
      StSave: begin
        epc_wr  = 1'b1;
        exl_set = 1'b1;
        flush   = 1'b1;
      end
      StVector: begin
        pc_redirect = 1'b1;
        redirect_pc = HandlerPc;
        flush       = 1'b1;
      end
      StEret: begin
        exl_clr     = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = epc;
        flush       = 1'b1;
      end
      default: ;
    endcase
  end

  assign cp0_pc = saved_pc_q;
  assign stall  = (state_q != StIdle) | take_int | take_eret;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
module tb_exc_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        int_req;
  logic        eret;
  logic        mem_valid;
  logic [29:0] mem_pc;
  logic        md_busy;
  logic [29:0] epc;
  logic [29:0] cp0_pc;
  logic        epc_wr;
  logic        exl_set;
  logic        exl_clr;
  logic        flush;
  logic        pc_redirect;
  logic [29:0] redirect_pc;
  logic        stall;
  logic        drain_timeout;

  int checks;
  int errors;

  localparam logic [29:0] HandlerPc = 30'h0000_1060;  // 32'h4180 >> 2

  exc_seq_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .int_req       (int_req),
    .eret          (eret),
    .mem_valid     (mem_valid),
    .mem_pc        (mem_pc),
    .md_busy       (md_busy),
    .epc           (epc),
    .cp0_pc        (cp0_pc),
    .epc_wr        (epc_wr),
    .exl_set       (exl_set),
    .exl_clr       (exl_clr),
    .flush         (flush),
    .pc_redirect   (pc_redirect),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .drain_timeout (drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed view of the pulse outputs: {epc_wr, exl_set, exl_clr, flush, pc_redirect, stall}
  function automatic logic [31:0] pulses();
    return {26'd0, epc_wr, exl_set, exl_clr, flush, pc_redirect, stall};
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    int_req   = 1'b1;
    eret      = 1'b0;
    mem_valid = 1'b1;
    mem_pc    = 30'h0000_0123;
    md_busy   = 1'b0;
    epc       = 30'h0;

    // Reset held 2 cycles with int_req asserted.
    tick();
    tick();
    settle();
    chk("rst_pulses", pulses(), 32'h0);
    chk("rst_cp0_pc", 32'(cp0_pc), 32'h0);
    chk("rst_redirect_pc", 32'(redirect_pc), 32'h0);
    chk("rst_timeout", 32'(drain_timeout), 32'h0);
    int_req = 1'b0;
    rst     = 1'b1;
    tick();
    settle();
    chk("post_rst_idle", pulses(), 32'h0);
    tick();
    settle();
    chk("post_rst_idle2", pulses(), 32'h0);

    // Interrupt, no drain.
    mem_pc  = 30'h0000_1005;
    int_req = 1'b1;
    settle();
    chk("int_detect_stall", pulses(), 32'h01);
    tick();
    int_req = 1'b0;
    settle();
    chk("int_save_pulses", pulses(), 32'h35);   // epc_wr exl_set flush stall
    chk("int_save_cp0_pc", 32'(cp0_pc), 32'h0000_1005);
    tick();
    settle();
    chk("int_vec_pulses", pulses(), 32'h07);    // flush pc_redirect stall
    chk("int_vec_target", 32'(redirect_pc), 32'(HandlerPc));
    chk("int_vec_cp0_pc", 32'(cp0_pc), 32'h0000_1005);
    tick();
    settle();
    chk("int_idle", pulses(), 32'h0);

    // Drain: md_busy high through 5 DRAIN cycles, int_req dropped meanwhile.
    mem_pc  = 30'h0000_0444;
    int_req = 1'b1;
    md_busy = 1'b1;
    settle();
    chk("drain_detect_stall", pulses(), 32'h01);
    tick();
    int_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) md_busy = 1'b0;
      settle();
      chk($sformatf("drain5_wait%0d", i), pulses(), 32'h01);
      tick();
    end
    settle();
    chk("drain5_save", pulses(), 32'h35);
    chk("drain5_cp0_pc", 32'(cp0_pc), 32'h0000_0444);
    chk("drain5_no_timeout", 32'(drain_timeout), 32'h0);
    tick();
    settle();
    chk("drain5_vec", 32'(redirect_pc), 32'(HandlerPc));
    tick();
    settle();
    chk("drain5_idle", pulses(), 32'h0);

    // ERET.
    epc  = 30'h0000_2010;
    eret = 1'b1;
    settle();
    chk("eret_detect_stall", pulses(), 32'h01);
    tick();
    eret = 1'b0;
    settle();
    chk("eret_pulses", pulses(), 32'h0F);       // exl_clr flush pc_redirect stall
    chk("eret_target", 32'(redirect_pc), 32'h0000_2010);
    tick();
    settle();
    chk("eret_idle", pulses(), 32'h0);

    // Simultaneous interrupt and ERET: interrupt wins.
    mem_pc  = 30'h0000_3000;
    int_req = 1'b1;
    eret    = 1'b1;
    tick();
    int_req = 1'b0;
    eret    = 1'b0;
    settle();
    chk("simul_save", pulses(), 32'h35);
    chk("simul_cp0_pc", 32'(cp0_pc), 32'h0000_3000);
    tick();
    settle();
    chk("simul_vec", pulses(), 32'h07);
    tick();
    settle();
    chk("simul_idle", pulses(), 32'h0);

    // Bubble: int_req with mem_valid low does nothing.
    mem_valid = 1'b0;
    mem_pc    = 30'h0000_0ABC;
    int_req   = 1'b1;
    settle();
    chk("bubble_stall", pulses(), 32'h0);
    tick();
    settle();
    chk("bubble_no_entry", pulses(), 32'h0);
    mem_valid = 1'b1;
    settle();
    chk("bubble_valid_stall", pulses(), 32'h01);
    tick();
    int_req = 1'b0;
    settle();
    chk("bubble_save", pulses(), 32'h35);
    chk("bubble_cp0_pc", 32'(cp0_pc), 32'h0000_0ABC);
    tick();
    tick();
    settle();
    chk("bubble_idle", pulses(), 32'h0);

    // md_busy stuck high: exactly 16 DRAIN cycles, then sticky timeout.
    mem_pc  = 30'h0000_0777;
    int_req = 1'b1;
    md_busy = 1'b1;
    tick();
    int_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk($sformatf("stuck_wait%0d", i), pulses(), 32'h01);
      if (i == 15) chk("stuck_timeout_pre", 32'(drain_timeout), 32'h0);
      tick();
    end
    settle();
    chk("stuck_save", pulses(), 32'h35);
    chk("stuck_timeout", 32'(drain_timeout), 32'h1);
    md_busy = 1'b0;
    tick();
    tick();
    settle();
    chk("stuck_idle", pulses(), 32'h0);
    chk("stuck_timeout_sticky", 32'(drain_timeout), 32'h1);

    // Reset mid-sequence (in SAVE) aborts with no further pulses.
    mem_pc  = 30'h0000_0999;
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    settle();
    chk("abort_save", pulses(), 32'h35);
    rst = 1'b0;
    tick();
    settle();
    chk("abort_rst_pulses", pulses(), 32'h0);
    chk("abort_rst_cp0_pc", 32'(cp0_pc), 32'h0);
    chk("abort_rst_timeout", 32'(drain_timeout), 32'h0);
    rst = 1'b1;
    tick();
    settle();
    chk("abort_after", pulses(), 32'h0);
    chk("abort_after_redirect", 32'(redirect_pc), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
